// File: rtl/mem_access_sched.sv
// -----------------------------------------------------------------------------
// mem_access_sched
//
// Arbitrates N_REQ iu cores onto one shared Memory instance. It uses a rotating
// priority pointer. The winner's address, write enable and write data are
// latched and held for the whole access. The Memory start/done handshake is
// driven from those latched values. Read data and a one-cycle completion pulse
// go back to the winner.
//
// Optional feature: define MEM_TIMEOUT_EN to add a WAIT-state watchdog. After
// TIMEOUT_CYCLES WAIT cycles without mem_done, the access is aborted. done and
// err pulse together and rdata is cleared. Without the macro, err is tied to 0.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   req, we          per-requester request (level) and write enable
//   addr, wdata      flattened per-requester address / write data
//   grant            one-hot owner of the in-flight transaction
//   done, err        one-cycle completion pulse (to owner) / watchdog abort
//   rdata            read data, valid with done, held until next capture
//   busy             high whenever the FSM is not IDLE
//   mem_start        one-cycle start pulse to Memory
//   mem_addr/we/wdata latched request driven to Memory
//   mem_rdata, mem_done  Memory read data and completion pulse
// -----------------------------------------------------------------------------
module mem_access_sched #(
    parameter int N_REQ          = 3,
    parameter int AW             = 11,
    parameter int DW             = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    we,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    done,
    output logic [DW-1:0]       rdata,
    output logic                err,
    output logic                busy,
    output logic                mem_start,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_we,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    input  logic                mem_done
);

    localparam int IW = $clog2(N_REQ);

    // Catch out-of-range configurations at elaboration.
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("mem_access_sched: N_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_access_sched: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t            state_reg, state_next;
    logic [IW-1:0]     ptr_reg;
    logic [IW-1:0]     idx_reg;
    logic [N_REQ-1:0]  grant_reg;
    logic [DW-1:0]     rdata_reg;
    logic [AW-1:0]     mem_addr_reg;
    logic              mem_we_reg;
    logic [DW-1:0]     mem_wdata_reg;

    logic              sel_valid;
    logic [IW-1:0]     sel_idx;
    logic [IW:0]       cand;
    logic              timeout_hit;

    // Per-requester views of the flattened buses.
    logic [AW-1:0] addr_arr  [N_REQ];
    logic [DW-1:0] wdata_arr [N_REQ];

    genvar gi;
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = addr[gi*AW +: AW];
        assign wdata_arr[gi] = wdata[gi*DW +: DW];
    end

    // Round-robin pick. The scan runs from the far end back toward ptr, so the
    // last hit is the requester closest to ptr. No early exit is needed.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = {1'b0, ptr_reg} + (IW+1)'(off);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (req[cand[IW-1:0]]) begin
                sel_valid = 1'b1;
                sel_idx   = cand[IW-1:0];
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tcnt_reg;
    logic          err_reg;

    // The count is the number of completed WAIT cycles. Seeing TIMEOUT_CYCLES-1
    // during a WAIT cycle means this is the last WAIT cycle allowed.
    // mem_done arriving in that same cycle takes priority over the abort.
    assign timeout_hit = (state_reg == ST_WAIT) && !mem_done &&
                         (tcnt_reg == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            err_reg <= timeout_hit;
            if (state_reg == ST_ISSUE) begin
                tcnt_reg <= '0;
            end else if (state_reg == ST_WAIT) begin
                tcnt_reg <= tcnt_reg + CW'(1);
            end
        end
    end

    assign err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (sel_valid) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (mem_done || timeout_hit) state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= '0;
            idx_reg       <= '0;
            grant_reg     <= '0;
            rdata_reg     <= '0;
            mem_addr_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (sel_valid) begin
                        idx_reg       <= sel_idx;
                        grant_reg     <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
                        mem_addr_reg  <= addr_arr[sel_idx];
                        mem_we_reg    <= we[sel_idx];
                        mem_wdata_reg <= wdata_arr[sel_idx];
                    end
                end
                ST_WAIT: begin
                    if (mem_done) begin
                        if (!mem_we_reg) rdata_reg <= mem_rdata;
                    end else if (timeout_hit) begin
                        rdata_reg <= '0;
                    end
                end
                ST_RESP: begin
                    ptr_reg   <= (idx_reg == IW'(N_REQ - 1)) ? '0 : idx_reg + IW'(1);
                    grant_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign grant     = grant_reg;
    assign done      = (state_reg == ST_RESP) ? grant_reg : '0;
    assign rdata     = rdata_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign mem_start = (state_reg == ST_ISSUE);
    assign mem_addr  = mem_addr_reg;
    assign mem_we    = mem_we_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_access_sched.sv
// -----------------------------------------------------------------------------
// tb_mem_access_sched
//
// Directed and randomized bench for mem_access_sched. A behavioural Memory
// answers the handshake. The expectations come from a transaction-level model:
// a round-robin pick over the pending requesters, a shadow memory array and the
// last read value.
// -----------------------------------------------------------------------------
module tb_mem_access_sched;

    localparam int N  = 3;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  we;
    logic [AW-1:0] addr_a  [N];
    logic [DW-1:0] wdata_a [N];
    logic [N*AW-1:0] addr_flat;
    logic [N*DW-1:0] wdata_flat;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic [DW-1:0] rdata;
    logic          err;
    logic          busy;
    logic          mem_start;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_done;

    // Environment memory (seen through the DUT's Memory port) and the model's
    // shadow memory (updated from what requesters asked for).
    logic [DW-1:0] mem_env [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_rdata;
    int            ref_ptr;
    int            passed = 0;
    int            failed = 0;
    int            total  = 0;
    int            txn_no = 0;

    always #5 clk = ~clk;

    always_comb begin
        addr_flat  = '0;
        wdata_flat = '0;
        for (int i = 0; i < N; i++) begin
            addr_flat[i*AW +: AW]  = addr_a[i];
            wdata_flat[i*DW +: DW] = wdata_a[i];
        end
    end

    mem_access_sched #(
        .N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr(addr_flat), .wdata(wdata_flat),
        .grant(grant), .done(done), .rdata(rdata), .err(err), .busy(busy),
        .mem_start(mem_start), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First pending requester at or after p, wrapping around.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic new_req(input int i);
        req[i]     = 1'b1;
        we[i]      = 1'($urandom_range(0, 1));
        addr_a[i]  = AW'($urandom);
        wdata_a[i] = DW'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'd0);
        chk({tag, "_err"},   32'(err),   32'd0);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_start"}, 32'(mem_start), 32'd0);
        chk({tag, "_maddr"}, 32'(mem_addr),  32'd0);
        chk({tag, "_mwe"},   32'(mem_we),    32'd0);
        chk({tag, "_mwd"},   32'(mem_wdata), 32'd0);
    endtask

    // Starts at the negedge of an IDLE cycle with req already driven. Ends at
    // the negedge of the RESP cycle. delay = cycles from mem_start to mem_done.
    // delay <= 0 means Memory never answers, so the watchdog ends the access.
    task automatic run_txn(input int delay, input bit spurious, input bit drop);
        int            w;
        logic [N-1:0]  oh;
        logic [AW-1:0] ea;
        logic          ewe;
        logic [DW-1:0] ewd;
        w = pick(req, ref_ptr);
        if (w < 0) begin
            chk("no_request", 32'(req), 32'd1);
            return;
        end
        oh  = N'(1) << w;
        ea  = addr_a[w];
        ewe = we[w];
        ewd = wdata_a[w];

        tick();   // ISSUE
        chk("issue_start", 32'(mem_start), 32'd1);
        chk("issue_grant", 32'(grant), 32'(oh));
        chk("issue_addr",  32'(mem_addr), 32'(ea));
        chk("issue_we",    32'(mem_we), 32'(ewe));
        chk("issue_wdata", 32'(mem_wdata), 32'(ewd));
        chk("issue_busy",  32'(busy), 32'd1);
        chk("issue_done",  32'(done), 32'd0);
        if (spurious) begin
            mem_done  = 1'b1;
            mem_rdata = 8'hEE;
        end

        if (delay > 0) begin
            for (int i = 1; i < delay; i++) begin
                tick();
                mem_done = 1'b0;
                chk("wait_start", 32'(mem_start), 32'd0);
                chk("wait_done",  32'(done), 32'd0);
                chk("wait_addr",  32'(mem_addr), 32'(ea));
                chk("wait_wdata", 32'(mem_wdata), 32'(ewd));
            end
            tick();   // WAIT cycle in which Memory completes
            chk("wait_we",    32'(mem_we), 32'(ewe));
            chk("wait_start", 32'(mem_start), 32'd0);
            mem_done = 1'b1;
            if (mem_we) begin
                mem_env[mem_addr] = mem_wdata;
                mem_rdata = DW'($urandom);
            end else begin
                mem_rdata = mem_env[mem_addr];
            end
            if (ewe) ref_mem[ea] = ewd;
            else     ref_rdata   = ref_mem[ea];
            tick();   // RESP
            mem_done = 1'b0;
            chk("resp_done",  32'(done), 32'(oh));
            chk("resp_rdata", 32'(rdata), 32'(ref_rdata));
            chk("resp_err",   32'(err), 32'd0);
            chk("resp_grant", 32'(grant), 32'(oh));
            chk("resp_busy",  32'(busy), 32'd1);
        end else begin
`ifdef MEM_TIMEOUT_EN
            for (int i = 0; i < TO; i++) begin
                tick();
                mem_done = 1'b0;
                chk("to_wait_done", 32'(done), 32'd0);
                chk("to_wait_busy", 32'(busy), 32'd1);
            end
            tick();   // RESP after the abort
            ref_rdata = '0;
            chk("to_done",  32'(done), 32'(oh));
            chk("to_err",   32'(err), 32'd1);
            chk("to_rdata", 32'(rdata), 32'(ref_rdata));
`endif
        end
        ref_ptr = (w + 1) % N;
        txn_no++;
        $display("txn %0d: req=%b winner=%0d we=%0b addr=%h wdata=%h rdata=%h next_ptr=%0d",
                 txn_no, req, w, ewe, ea, ewd, ref_rdata, ref_ptr);
        if (drop) req[w] = 1'b0;
    endtask

    // From the RESP negedge, step into IDLE and confirm that everything released.
    task automatic idle_check();
        tick();
        chk("idle_busy",  32'(busy), 32'd0);
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_done",  32'(done), 32'd0);
        chk("idle_err",   32'(err), 32'd0);
        chk("idle_start", 32'(mem_start), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        we  = '0;
        mem_done  = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < N; i++) begin
            addr_a[i]  = '0;
            wdata_a[i] = '0;
        end
        for (int i = 0; i < (1 << AW); i++) begin
            mem_env[i] = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end
        ref_ptr   = 0;
        ref_rdata = '0;

        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // A stray mem_done while idle does nothing.
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("idle_spur_busy",  32'(busy), 32'd0);
        chk("idle_spur_start", 32'(mem_start), 32'd0);
        tick();
        chk("idle_spur_busy2", 32'(busy), 32'd0);

        // Directed read.
        mem_env[11'h155] = 8'hA5;
        ref_mem[11'h155] = 8'hA5;
        addr_a[0] = 11'h155;
        we = '0;
        req = 3'b001;
        run_txn(3, 1'b0, 1'b1);
        idle_check();

        // Directed write; rdata keeps the earlier A5.
        addr_a[1]  = 11'h020;
        wdata_a[1] = 8'h3C;
        we  = 3'b010;
        req = 3'b010;
        run_txn(2, 1'b1, 1'b1);
        idle_check();
        chk("write_rdata_hold", 32'(rdata), 32'h0A5);

        // Contention from reset: all three held, expect 0,1,2,0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ref_ptr   = 0;
        ref_rdata = '0;
        we = '0;
        addr_a[0] = 11'h010;
        addr_a[1] = 11'h011;
        addr_a[2] = 11'h012;
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            run_txn(1 + k, 1'b0, 1'b0);
            idle_check();
        end
        req = '0;

        // Fairness: serve 1 (ptr=2), then 011 -> 0; serve 1 again, then 110 -> 2.
        req = 3'b010;
        run_txn(1, 1'b0, 1'b1);
        idle_check();
        req = 3'b011;
        run_txn(2, 1'b0, 1'b1);
        chk("fair_first_0", 32'(grant), 32'b001);
        idle_check();
        run_txn(1, 1'b0, 1'b1);
        idle_check();
        req = 3'b110;
        run_txn(1, 1'b0, 1'b1);
        chk("fair_first_2", 32'(grant), 32'b100);
        idle_check();
        req = '0;

        // Reset while WAIT is in progress.
        we[1]      = 1'b1;
        addr_a[1]  = 11'h7FF;
        wdata_a[1] = 8'h99;
        req = 3'b010;
        tick();
        chk("pre_rst_start", 32'(mem_start), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk_all_zero("rst_wait");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        ref_ptr   = 0;
        ref_rdata = '0;
        req = '0;
        we  = '0;
        addr_a[2] = 11'h123;
        req = 3'b100;
        run_txn(2, 1'b0, 1'b1);
        idle_check();

        // Randomized traffic that respects the requester contract.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) new_req(i);
            end
            if (req == '0) new_req(int'($urandom_range(0, N - 1)));
            run_txn(int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
            idle_check();
        end
        req = '0;

`ifdef MEM_TIMEOUT_EN
        // Memory never answers, so the watchdog ends the access.
        we[0]     = 1'b0;
        addr_a[0] = 11'h155;
        req = 3'b001;
        run_txn(0, 1'b0, 1'b1);
        idle_check();
`endif

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
